// File: rtl/div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle, with signed/unsigned mode,
// divide-by-zero flag and cancel. Quotient feeds LO and remainder feeds HI.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_i,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] abs_dividend, abs_divisor, raw_dividend;

    always_comb begin
        abs_dividend = (signed_i && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_divisor  = (signed_i && divisor[WIDTH-1])  ? -divisor  : divisor;
        // Before any step quo_q still holds |dividend|; undo the abs to recover the raw operand.
        raw_dividend = (mode_q && rsign_q) ? -quo_q : quo_q;
        trial        = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            step_rem = trial[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            step_quo = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    state_d = CALC;
                    rem_d   = '0;
                    quo_d   = abs_dividend;
                    dvs_d   = abs_divisor;
                    qsign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rsign_d = dividend[WIDTH-1];
                    mode_d  = signed_i;
                    cnt_d   = CW'(WIDTH);
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (dvs_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    quot_d  = '1;
                    remo_d  = raw_dividend;
                    dbz_d   = 1'b1;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        quot_d  = (mode_q && qsign_q) ? -step_quo : step_quo;
                        remo_d  = (mode_q && rsign_q) ? -step_rem : step_rem;
                        dbz_d   = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign ready       = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboarded bench for div_iter at WIDTH=32 and WIDTH=8: directed corner cases,
// cancel/reset/protocol scenarios and randomized operations against an arithmetic model.
module tb_div_iter;
    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        s32_start = 1'b0, s32_sg = 1'b0, s32_cancel = 1'b0;
    logic [31:0] s32_a = '0, s32_b = '0;
    logic        b32, r32, z32;
    logic [31:0] q32, m32;

    logic        s8_start = 1'b0, s8_sg = 1'b0, s8_cancel = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        b8, r8, z8;
    logic [7:0]  q8, m8;

    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   txn32   = 0;
    int   txn8    = 0;
    exp_t sb32[$];
    exp_t sb8[$];
    exp_t last32  = '0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) u_div32 (
        .clk(clk), .rst(rst), .start(s32_start), .signed_i(s32_sg), .cancel(s32_cancel),
        .dividend(s32_a), .divisor(s32_b), .busy(b32), .ready(r32),
        .quotient(q32), .remainder(m32), .div_by_zero(z32)
    );

    div_iter #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .start(s8_start), .signed_i(s8_sg), .cancel(s8_cancel),
        .dividend(s8_a), .divisor(s8_b), .busy(b8), .ready(r8),
        .quotient(q8), .remainder(m8), .div_by_zero(z8)
    );

    // Reference: plain integer division on sign-extended operands, results taken modulo 2^w.
    function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic sg);
        exp_t        e;
        logic [63:0] m, a, b;
        longint      sa, sb;
        m = (64'd1 << w) - 64'd1;
        a = a_in & m;
        b = b_in & m;
        if (b == 64'd0) begin
            e.q = m;
            e.r = a;
            e.z = 1'b1;
        end else if (sg) begin
            sa  = $signed(a << (64 - w));
            sa  = sa >>> (64 - w);
            sb  = $signed(b << (64 - w));
            sb  = sb >>> (64 - w);
            e.q = sa / sb;
            e.q = e.q & m;
            e.r = sa % sb;
            e.r = e.r & m;
            e.z = 1'b0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: every ready pulse consumes one expected result.
    always @(negedge clk) begin : monitor
        exp_t e32, e8;
        if (rst && r32) begin
            cmp_cnt++;
            txn32++;
            if (sb32.size() == 0) begin
                err_cnt++;
                $display("FAIL w32_unexpected_ready: txn %0d got ready=1, required no result", txn32);
            end else begin
                e32 = sb32.pop_front();
                if ({32'b0, q32} !== e32.q || {32'b0, m32} !== e32.r || z32 !== e32.z) begin
                    err_cnt++;
                    $display("FAIL w32_result: txn %0d got q=%h r=%h z=%b, required q=%h r=%h z=%b",
                             txn32, q32, m32, z32, e32.q[31:0], e32.r[31:0], e32.z);
                end else begin
                    $display("w32 txn %0d: q=%h r=%h z=%b ok", txn32, q32, m32, z32);
                end
            end
        end
        if (rst && r8) begin
            cmp_cnt++;
            txn8++;
            if (sb8.size() == 0) begin
                err_cnt++;
                $display("FAIL w8_unexpected_ready: txn %0d got ready=1, required no result", txn8);
            end else begin
                e8 = sb8.pop_front();
                if ({56'b0, q8} !== e8.q || {56'b0, m8} !== e8.r || z8 !== e8.z) begin
                    err_cnt++;
                    $display("FAIL w8_result: txn %0d got q=%h r=%h z=%b, required q=%h r=%h z=%b",
                             txn8, q8, m8, z8, e8.q[7:0], e8.r[7:0], e8.z);
                end else begin
                    $display("w8 txn %0d: q=%h r=%h z=%b ok", txn8, q8, m8, z8);
                end
            end
        end
    end

    task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic sg);
        exp_t e;
        int   n, lat;
        logic seen, busy_ok, rd, bz;
        e = model(w, a, b, sg);
        @(negedge clk);
        if (w == 32) begin
            s32_start = 1'b1; s32_a = a[31:0]; s32_b = b[31:0]; s32_sg = sg;
            sb32.push_back(e);
            last32 = e;
        end else begin
            s8_start = 1'b1; s8_a = a[7:0]; s8_b = b[7:0]; s8_sg = sg;
            sb8.push_back(e);
        end
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (w == 32) s32_start = 1'b0;
                else         s8_start  = 1'b0;
            end
            rd = (w == 32) ? r32 : r8;
            bz = (w == 32) ? b32 : b8;
            if (!bz) busy_ok = 1'b0;
            if (rd) seen = 1'b1;
        end
        lat = (e.z) ? 2 : w + 1;
        if (!seen) chk("ready_timeout", 64'd0, 64'd1);
        else begin
            chk("latency", 64'(n), 64'(lat));
            chk("busy_during_op", {63'b0, busy_ok}, 64'd1);
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   n, r1, r2, extra, rdy_cnt;
        exp_t e;
        logic [31:0] ra, rb;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'b0, b32}, 64'd0);
        chk("rst_ready", {63'b0, r32}, 64'd0);
        chk("rst_quotient", {32'b0, q32}, 64'd0);
        chk("rst_remainder", {32'b0, m32}, 64'd0);
        chk("rst_dbz", {63'b0, z32}, 64'd0);
        rst = 1'b1;

        // Directed WIDTH=32 operations
        run_op(32, 100, 7, 1'b0);
        chk("q_100_7", {32'b0, q32}, 64'd14);
        chk("r_100_7", {32'b0, m32}, 64'd2);
        run_op(32, 64'hFFFF_FFF9, 2, 1'b1);
        chk("q_m7_2", {32'b0, q32}, 64'hFFFF_FFFD);
        chk("r_m7_2", {32'b0, m32}, 64'hFFFF_FFFF);
        run_op(32, 7, 64'hFFFF_FFFE, 1'b1);
        chk("q_7_m2", {32'b0, q32}, 64'hFFFF_FFFD);
        chk("r_7_m2", {32'b0, m32}, 64'd1);
        run_op(32, 64'hFFFF_FFF9, 2, 1'b0);
        run_op(32, 7, 64'hFFFF_FFFE, 1'b0);
        run_op(32, 64'h1234, 0, 1'b0);
        chk("dz_quotient", {32'b0, q32}, 64'hFFFF_FFFF);
        chk("dz_remainder", {32'b0, m32}, 64'h1234);
        chk("dz_flag", {63'b0, z32}, 64'd1);
        run_op(32, 64'hFFFF_FFF0, 0, 1'b1);
        run_op(32, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1);
        chk("ovf_quotient", {32'b0, q32}, 64'h8000_0000);
        chk("ovf_remainder", {32'b0, m32}, 64'd0);
        chk("ovf_flag", {63'b0, z32}, 64'd0);

        // Cancel at iteration 10: no ready, previous result held
        @(negedge clk);
        s32_start = 1'b1; s32_a = 1000; s32_b = 3; s32_sg = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) s32_start = 1'b0;
        end
        s32_cancel = 1'b1;
        @(negedge clk);
        s32_cancel = 1'b0;
        chk("cancel_busy", {63'b0, b32}, 64'd0);
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r32) rdy_cnt++;
        end
        chk("cancel_no_ready", 64'(rdy_cnt), 64'd0);
        chk("cancel_hold_q", {32'b0, q32}, last32.q);
        chk("cancel_hold_r", {32'b0, m32}, last32.r);
        chk("cancel_hold_z", {63'b0, z32}, {63'b0, last32.z});

        // Start and cancel together: request dropped
        @(negedge clk);
        s32_start = 1'b1; s32_cancel = 1'b1; s32_a = 5; s32_b = 1;
        @(negedge clk);
        s32_start = 1'b0; s32_cancel = 1'b0;
        chk("start_cancel_busy", {63'b0, b32}, 64'd0);
        run_op(32, 1000, 3, 1'b0);

        // start held high: accepted once per IDLE, ready pulses 34 cycles apart
        e = model(32, 100, 7, 1'b0);
        @(negedge clk);
        s32_start = 1'b1; s32_a = 100; s32_b = 7; s32_sg = 1'b0;
        sb32.push_back(e);
        sb32.push_back(e);
        last32 = e;
        r1 = -1; r2 = -1; extra = 0;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk);
            if (r32) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
                else extra++;
            end
            if (i == 67) s32_start = 1'b0;
        end
        chk("b2b_first_ready", 64'(r1), 64'd33);
        chk("b2b_spacing", 64'(r2 - r1), 64'd34);
        chk("b2b_extra_ready", 64'(extra), 64'd0);
        chk("b2b_idle_after", {63'b0, b32}, 64'd0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        s32_start = 1'b1; s32_a = 123456; s32_b = 789; s32_sg = 1'b0;
        @(negedge clk);
        s32_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {63'b0, b32}, 64'd0);
        chk("midrst_ready", {63'b0, r32}, 64'd0);
        chk("midrst_quotient", {32'b0, q32}, 64'd0);
        chk("midrst_remainder", {32'b0, m32}, 64'd0);
        chk("midrst_dbz", {63'b0, z32}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r32 || b32) rdy_cnt++;
        end
        chk("postrst_quiet", 64'(rdy_cnt), 64'd0);

        // Randomized WIDTH=32
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                3:       begin rb = $urandom; ra = 32'h8000_0000; end
                default: rb = $urandom;
            endcase
            run_op(32, {32'b0, ra}, {32'b0, rb}, 1'($urandom_range(0, 1)));
        end

        // WIDTH=8 directed
        run_op(8, 200, 3, 1'b0);
        chk("w8_q_200_3", {56'b0, q8}, 64'd66);
        chk("w8_r_200_3", {56'b0, m8}, 64'd2);
        run_op(8, 64'h80, 64'hFF, 1'b1);
        chk("w8_ovf_q", {56'b0, q8}, 64'h80);
        chk("w8_ovf_r", {56'b0, m8}, 64'd0);

        // Randomized WIDTH=8, both modes
        for (int i = 0; i < 2000; i++) begin
            ra = $urandom_range(0, 255);
            rb = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            run_op(8, {32'b0, ra}, {32'b0, rb}, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("sb32_drained", 64'(sb32.size()), 64'd0);
        chk("sb8_drained", 64'(sb8.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
